// File: rtl/snake_frame_renderer_if.sv
// snake_frame_renderer_if: pixel/game-state inputs and classified pixel outputs of the snake frame renderer
//   master drives X/Y, head/fruit/body positions, body write strobe and snake_length
//   slave (the renderer) returns block/local coordinates, area flags, figure/colour codes and load_overflow
interface snake_frame_renderer_if #(
  parameter int PIXEL_DISPLAY_BIT = 9,
  parameter int COORD_BITS        = 7,
  parameter int BLOCK_SHIFT       = 3,
  parameter int LEN_BITS          = 5
);
  logic [PIXEL_DISPLAY_BIT:0] X, Y;
  logic [COORD_BITS-1:0]      snake_head_x, snake_head_y, fruit_x, fruit_y, snake_body_x, snake_body_y;
  logic                       en_snake_body;
  logic [LEN_BITS-1:0]        snake_length;
  logic [COORD_BITS-1:0]      x_block, y_block;
  logic [BLOCK_SHIFT-1:0]     x_local, y_local;
  logic                       game_enable, game_area, semaforo, load_overflow;
  logic [1:0]                 selected_figure, color_data;
  modport master (
    output X, Y, snake_head_x, snake_head_y, fruit_x, fruit_y, snake_body_x, snake_body_y, en_snake_body, snake_length,
    input  x_block, y_block, x_local, y_local, game_enable, game_area, semaforo, load_overflow, selected_figure, color_data
  );
  modport slave (
    input  X, Y, snake_head_x, snake_head_y, fruit_x, fruit_y, snake_body_x, snake_body_y, en_snake_body, snake_length,
    output x_block, y_block, x_local, y_local, game_enable, game_area, semaforo, load_overflow, selected_figure, color_data
  );
endinterface

// File: rtl/snake_frame_renderer.sv
// snake_frame_renderer: maps VGA pixel counters to game blocks and classifies each pixel as background/head/body/fruit
//   clock_25 : pixel clock
//   reset    : asynchronous active-low reset
//   bus      : snake_frame_renderer_if.slave (pixel position and game state in, classified pixel out)
//   Outputs other than load_overflow lag the sampled X/Y by two cycles.
//   Optional macro FRUIT_BLINK_EN: fruit is hidden while the MSB of a per-frame counter is set.
module snake_frame_renderer #(
  parameter int PIXEL_DISPLAY_BIT = 9,
  parameter int V_ACTIVE          = 480,
  parameter int H_ACTIVE          = 640,
  parameter int GAME_X0           = 0,
  parameter int GAME_Y0           = 0,
  parameter int GAME_W            = 64,
  parameter int GAME_H            = 48,
  parameter int BLOCK_SHIFT       = 3,
  parameter int COORD_BITS        = 7,
  parameter int MAX_LENGTH        = 16,
`ifdef FRUIT_BLINK_EN
  parameter int BLINK_BITS        = 5,
`endif
  parameter int LEN_BITS          = 5
) (
  input logic clock_25,
  input logic reset,
  snake_frame_renderer_if.slave bus
);
  localparam int W  = PIXEL_DISPLAY_BIT + 1;
  localparam int E  = 2 * COORD_BITS;
  localparam int IW = MAX_LENGTH > 1 ? $clog2(MAX_LENGTH) : 1;
  typedef logic [W-1:0] pix_t;
  typedef logic [LEN_BITS-1:0] len_t;
  localparam pix_t X0   = pix_t'(GAME_X0);
  localparam pix_t Y0   = pix_t'(GAME_Y0);
  localparam len_t LMAX = len_t'(MAX_LENGTH);
  pix_t dx, dy, bx, by;
  logic en_c, area_c, swap, hit, fruit_vis;
  logic s1_en, s1_area, s1_sem;
  logic [COORD_BITS-1:0] s1_xb, s1_yb;
  logic [BLOCK_SHIFT-1:0] s1_xl, s1_yl;
  logic [E-1:0] shadow [MAX_LENGTH];
  logic [E-1:0] active [MAX_LENGTH];
  logic [E-1:0] head_q, fruit_q;
  len_t wr_ptr, active_length;
  logic overflow_pending, wr_ok;
  logic [IW-1:0] wr_idx;
  logic [1:0] fig_c, col_c;
  assign dx = bus.X - X0;
  assign dy = bus.Y - Y0;
  assign bx = dx >> BLOCK_SHIFT;
  assign by = dy >> BLOCK_SHIFT;
  assign en_c = bus.X < pix_t'(H_ACTIVE) && bus.Y < pix_t'(V_ACTIVE);
  assign area_c = en_c && bus.X >= X0 && bus.Y >= Y0 && bx < pix_t'(GAME_W) && by < pix_t'(GAME_H);
  assign swap = bus.X == '0 && bus.Y == '0;
  // a write on the swap cycle starts the new load at entry 0
  assign wr_ok = bus.en_snake_body && (swap || wr_ptr != LMAX);
  assign wr_idx = swap ? '0 : wr_ptr[IW-1:0];
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      s1_en   <= 1'b0;
      s1_area <= 1'b0;
      s1_sem  <= 1'b0;
      s1_xb   <= '0;
      s1_yb   <= '0;
      s1_xl   <= '0;
      s1_yl   <= '0;
    end else begin
      s1_en   <= en_c;
      s1_area <= area_c;
      s1_sem  <= bus.Y >= pix_t'(V_ACTIVE);
      s1_xb   <= area_c ? COORD_BITS'(bx) : '0;
      s1_yb   <= area_c ? COORD_BITS'(by) : '0;
      s1_xl   <= area_c ? dx[BLOCK_SHIFT-1:0] : '0;
      s1_yl   <= area_c ? dy[BLOCK_SHIFT-1:0] : '0;
    end
  end
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LENGTH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      wr_ptr            <= '0;
      active_length     <= '0;
      head_q            <= '0;
      fruit_q           <= '0;
      overflow_pending  <= 1'b0;
      bus.load_overflow <= 1'b0;
    end else begin
      if (wr_ok) shadow[wr_idx] <= {bus.snake_body_x, bus.snake_body_y};
      if (swap) begin
        active            <= shadow;
        active_length     <= bus.snake_length > LMAX ? LMAX : bus.snake_length;
        head_q            <= {bus.snake_head_x, bus.snake_head_y};
        fruit_q           <= {bus.fruit_x, bus.fruit_y};
        bus.load_overflow <= overflow_pending;
      end
      wr_ptr <= swap ? len_t'(bus.en_snake_body) : wr_ok ? wr_ptr + 1'b1 : wr_ptr;
      overflow_pending <= swap ? 1'b0 : (bus.en_snake_body && !wr_ok) || overflow_pending;
    end
  end
`ifdef FRUIT_BLINK_EN
  logic [BLINK_BITS-1:0] blink;
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) blink <= '0;
    else if (swap) blink <= blink + 1'b1;
  end
  assign fruit_vis = !blink[BLINK_BITS-1];
`else
  assign fruit_vis = 1'b1;
`endif
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_LENGTH; i++)
      hit = hit | (len_t'(i) < active_length && active[i] == {s1_xb, s1_yb});
  end
  assign fig_c = !s1_area ? 2'b00 :
                 head_q == {s1_xb, s1_yb} ? 2'b01 :
                 hit ? 2'b10 :
                 fruit_vis && fruit_q == {s1_xb, s1_yb} ? 2'b11 : 2'b00;
  assign col_c = !s1_area ? 2'b00 : fig_c == 2'b00 ? 2'b01 : fig_c == 2'b11 ? 2'b11 : 2'b10;
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      bus.game_enable     <= 1'b0;
      bus.game_area       <= 1'b0;
      bus.semaforo        <= 1'b0;
      bus.x_block         <= '0;
      bus.y_block         <= '0;
      bus.x_local         <= '0;
      bus.y_local         <= '0;
      bus.selected_figure <= 2'b00;
      bus.color_data      <= 2'b00;
    end else begin
      bus.game_enable     <= s1_en;
      bus.game_area       <= s1_area;
      bus.semaforo        <= s1_sem;
      bus.x_block         <= s1_xb;
      bus.y_block         <= s1_yb;
      bus.x_local         <= s1_xl;
      bus.y_local         <= s1_yl;
      bus.selected_figure <= fig_c;
      bus.color_data      <= col_c;
    end
  end
endmodule

// File: tb/tb_snake_frame_renderer.sv
// tb_snake_frame_renderer: directed checks of the snake frame renderer (default build, 8x8 blocks, 16 body entries)
module tb_snake_frame_renderer;
  logic clock_25 = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  snake_frame_renderer_if bus ();
  snake_frame_renderer dut (.clock_25(clock_25), .reset(reset), .bus(bus));
  always #20 clock_25 = ~clock_25;
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal;
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic pix(input int x, input int y);
    @(negedge clock_25);
    bus.X = 10'(x);
    bus.Y = 10'(y);
    repeat (2) @(negedge clock_25);
  endtask
  task automatic fig(input string tag, input logic [1:0] f, input logic [1:0] c);
    chk({tag, "_fig"}, 16'(bus.selected_figure), 16'(f));
    chk({tag, "_col"}, 16'(bus.color_data), 16'(c));
  endtask
  task automatic swap_frame();
    @(negedge clock_25);
    bus.X = 10'd0;
    bus.Y = 10'd0;
    @(negedge clock_25);
    bus.X = 10'd1;
    bus.Y = 10'd1;
  endtask
  task automatic wr(input int bx, input int by);
    @(negedge clock_25);
    bus.snake_body_x = 7'(bx);
    bus.snake_body_y = 7'(by);
    bus.en_snake_body = 1'b1;
    @(negedge clock_25);
    bus.en_snake_body = 1'b0;
  endtask
  task automatic set_game(input int hx, input int hy, input int fx, input int fy, input int len);
    bus.snake_head_x = 7'(hx);
    bus.snake_head_y = 7'(hy);
    bus.fruit_x = 7'(fx);
    bus.fruit_y = 7'(fy);
    bus.snake_length = 5'(len);
  endtask
  initial begin
    bus.X = 10'd300;
    bus.Y = 10'd100;
    set_game(0, 0, 0, 0, 0);
    bus.snake_body_x = '0;
    bus.snake_body_y = '0;
    bus.en_snake_body = 1'b0;
    repeat (3) @(negedge clock_25);
    chk("por_color", 16'(bus.color_data), 16'd0);
    chk("por_enable", 16'(bus.game_enable), 16'd0);
    reset = 1'b1;
    pix(300, 100);
    fig("bg", 2'b00, 2'b01);
    chk("bg_xblock", 16'(bus.x_block), 16'd37);
    chk("bg_yblock", 16'(bus.y_block), 16'd12);
    chk("bg_xlocal", 16'(bus.x_local), 16'd4);
    chk("bg_ylocal", 16'(bus.y_local), 16'd4);
    chk("bg_enable", 16'(bus.game_enable), 16'd1);
    chk("bg_area", 16'(bus.game_area), 16'd1);
    chk("bg_sem", 16'(bus.semaforo), 16'd0);
    #5 reset = 1'b0;
    #1;
    chk("rst_color", 16'(bus.color_data), 16'd0);
    chk("rst_xblock", 16'(bus.x_block), 16'd0);
    chk("rst_enable", 16'(bus.game_enable), 16'd0);
    chk("rst_area", 16'(bus.game_area), 16'd0);
    @(negedge clock_25);
    reset = 1'b1;
    pix(300, 100);
    fig("resume", 2'b00, 2'b01);
    set_game(2, 2, 30, 30, 0);
    swap_frame();
    pix(16, 16);
    fig("head", 2'b01, 2'b10);
    chk("head_xblock", 16'(bus.x_block), 16'd2);
    chk("head_yblock", 16'(bus.y_block), 16'd2);
    chk("head_xlocal", 16'(bus.x_local), 16'd0);
    pix(23, 16);
    chk("head_xlocal7", 16'(bus.x_local), 16'd7);
    fig("head_edge", 2'b01, 2'b10);
    wr(8, 8);
    wr(1, 1);
    bus.snake_length = 5'd2;
    pix(64, 64);
    fig("body_preswap", 2'b00, 2'b01);
    swap_frame();
    pix(64, 64);
    fig("body_a", 2'b10, 2'b10);
    pix(8, 8);
    fig("body_b", 2'b10, 2'b10);
    wr(8, 8);
    wr(1, 1);
    bus.snake_length = 5'd1;
    swap_frame();
    pix(64, 64);
    fig("len1_a", 2'b10, 2'b10);
    pix(8, 8);
    fig("len1_b", 2'b00, 2'b01);
    for (int i = 0; i < 17; i++) wr(10 + i, 20);
    bus.snake_length = 5'd20;
    chk("ovf_before", 16'(bus.load_overflow), 16'd0);
    swap_frame();
    chk("ovf_set", 16'(bus.load_overflow), 16'd1);
    pix(80, 160);
    fig("ovf_first", 2'b10, 2'b10);
    pix(200, 160);
    fig("ovf_16th", 2'b10, 2'b10);
    pix(208, 160);
    fig("ovf_17th", 2'b00, 2'b01);
    chk("ovf_hold", 16'(bus.load_overflow), 16'd1);
    swap_frame();
    chk("ovf_clear", 16'(bus.load_overflow), 16'd0);
    set_game(4, 4, 4, 4, 1);
    swap_frame();
    pix(32, 32);
    fig("head_over_fruit", 2'b01, 2'b10);
    set_game(2, 2, 5, 5, 1);
    swap_frame();
    pix(40, 40);
    fig("fruit", 2'b11, 2'b11);
    @(negedge clock_25);
    bus.X = 10'd0;
    bus.Y = 10'd0;
    bus.snake_body_x = 7'd6;
    bus.snake_body_y = 7'd6;
    bus.en_snake_body = 1'b1;
    @(negedge clock_25);
    bus.en_snake_body = 1'b0;
    bus.X = 10'd1;
    bus.Y = 10'd1;
    pix(80, 160);
    fig("swapwr_old", 2'b10, 2'b10);
    pix(48, 48);
    fig("swapwr_new_hidden", 2'b00, 2'b01);
    swap_frame();
    pix(48, 48);
    fig("swapwr_new", 2'b10, 2'b10);
    pix(80, 160);
    fig("swapwr_old_gone", 2'b00, 2'b01);
    pix(650, 490);
    fig("blank", 2'b00, 2'b00);
    chk("blank_enable", 16'(bus.game_enable), 16'd0);
    chk("blank_area", 16'(bus.game_area), 16'd0);
    chk("blank_sem", 16'(bus.semaforo), 16'd1);
    chk("blank_xblock", 16'(bus.x_block), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
